// File: rtl/axi_arb_pkg.sv
// Shared arbitration types and the round-robin pick function.
// Used by the AXI channel arbiters; rr_pick works on up to MAX_REQ requesters.
package axi_arb_pkg;

   localparam int unsigned MAX_REQ = 16;
   localparam int unsigned PTR_W   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // One-hot winner: first asserted valid found from ptr upward, modulo n.
   // Bits at and above n are ignored, and ptr is expected to be below n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [PTR_W-1:0]   ptr,
                                                  input int unsigned        n);
      logic [MAX_REQ-1:0] pick;
      logic               found;
      logic [PTR_W-1:0]   src;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         // Rotate by ptr, priority-encode, and map the hit back to its index.
         src = PTR_W'((32'(ptr) + i) % n);
         if ((i < n) && !found && valid[src]) begin
            found     = 1'b1;
            pick[src] = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational rotating-priority selector.
// Ports: valid_i  - request vector
//        ptr_i    - index with the highest priority
//        win_c_o  - one-hot winner (all zero when no request)
module rr_select
   import axi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] win_c_o
);

   logic [MAX_REQ-1:0] valid_ext;

   always_comb begin
      valid_ext                = '0;
      valid_ext[NUM_REQ-1:0]   = valid_i;
      win_c_o = NUM_REQ'(rr_pick(valid_ext, PTR_W'(ptr_i), NUM_REQ));
   end

endmodule

// File: rtl/axi_rr_arbiter_n.sv
// N-requester AXI channel arbiter with grant hold until handshake (or last beat).
// Ports: ACLK, ARESET (sync, active-high)
//        req_valid/req_last - per-requester VALID and LAST
//        out_ready          - downstream READY
//        grant_onehot/grant_idx/grant_active - registered grant state
//        req_ready          - combinational READY back to the owner only
module axi_rr_arbiter_n
   import axi_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ      = 3,
   parameter  int unsigned ROUND_ROBIN  = 1,
   parameter  int unsigned HOLD_TO_LAST = 0,
   localparam int unsigned IDX_W        = $clog2(NUM_REQ)
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [NUM_REQ-1:0] req_last,
   input  logic               out_ready,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_active,
   output logic [NUM_REQ-1:0] req_ready
);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   sel_ptr;
   logic [NUM_REQ-1:0] win;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   next_ptr;
   logic               owner_hs;
   logic               owner_last;
   logic               release_ev;

   // Fixed priority is round-robin with the pointer pinned to 0.
   assign sel_ptr = (ROUND_ROBIN != 0) ? ptr_q : '0;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_select (
      .valid_i (req_valid),
      .ptr_i   (sel_ptr),
      .win_c_o (win)
   );

   // One-hot to binary for the winner.
   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win[i]) win_idx = IDX_W'(i);
      end
   end

   // Release detection for the current owner and the post-release pointer.
   always_comb begin
      owner_hs   = out_ready & (|(req_valid & grant_q));
      owner_last = |(req_last & grant_q);
      release_ev = owner_hs & ((HOLD_TO_LAST == 0) | owner_last);
      next_ptr   = (32'(idx_q) == NUM_REQ - 1) ? '0 : IDX_W'(idx_q + 1'b1);
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d = BUSY;
               grant_d = win;
               idx_d   = win_idx;
            end
         end
         BUSY: begin
            if (release_ev) begin
               state_d = IDLE;
               grant_d = '0;
               idx_d   = '0;
               ptr_d   = (ROUND_ROBIN != 0) ? next_ptr : '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
         end
      endcase
   end

   // State and grant registers.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_onehot = grant_q;
   assign grant_idx    = idx_q;
   assign grant_active = (state_q == BUSY);
   assign req_ready    = grant_q & {NUM_REQ{out_ready}};

endmodule

// File: tb/tb_axi_rr_arbiter_n.sv
// Directed bench for axi_rr_arbiter_n: three instances (round-robin,
// fixed priority, burst hold) sharing clock and reset.
module tb_axi_rr_arbiter_n;

   logic       clk = 1'b0;
   logic       rst;

   logic [2:0] a_valid, a_last, a_gnt, a_rdy;
   logic       a_ready, a_act;
   logic [1:0] a_idx;

   logic [2:0] b_valid, b_last, b_gnt, b_rdy;
   logic       b_ready, b_act;
   logic [1:0] b_idx;

   logic [2:0] c_valid, c_last, c_gnt, c_rdy;
   logic       c_ready, c_act;
   logic [1:0] c_idx;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_rr_arbiter_n #(.NUM_REQ(3), .ROUND_ROBIN(1), .HOLD_TO_LAST(0)) u_rr (
      .ACLK(clk), .ARESET(rst), .req_valid(a_valid), .req_last(a_last),
      .out_ready(a_ready), .grant_onehot(a_gnt), .grant_idx(a_idx),
      .grant_active(a_act), .req_ready(a_rdy));

   axi_rr_arbiter_n #(.NUM_REQ(3), .ROUND_ROBIN(0), .HOLD_TO_LAST(0)) u_fp (
      .ACLK(clk), .ARESET(rst), .req_valid(b_valid), .req_last(b_last),
      .out_ready(b_ready), .grant_onehot(b_gnt), .grant_idx(b_idx),
      .grant_active(b_act), .req_ready(b_rdy));

   axi_rr_arbiter_n #(.NUM_REQ(3), .ROUND_ROBIN(1), .HOLD_TO_LAST(1)) u_burst (
      .ACLK(clk), .ARESET(rst), .req_valid(c_valid), .req_last(c_last),
      .out_ready(c_ready), .grant_onehot(c_gnt), .grant_idx(c_idx),
      .grant_active(c_act), .req_ready(c_rdy));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] rot_gnt [6];
   logic [1:0] rot_idx [6];

   initial begin
      rot_gnt = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      rot_idx = '{2'd0,   2'd1,   2'd0,   2'd2,   2'd0,   2'd0};

      rst     = 1'b1;
      a_valid = 3'b111; a_last = 3'b000; a_ready = 1'b1;
      b_valid = 3'b000; b_last = 3'b000; b_ready = 1'b0;
      c_valid = 3'b000; c_last = 3'b000; c_ready = 1'b0;

      // Reset held with requests pending.
      step;
      chk("rst_gnt_0", a_gnt, 3'b000);
      chk("rst_act_0", a_act, 0);
      step;
      chk("rst_gnt_1", a_gnt, 3'b000);
      chk("rst_act_1", a_act, 0);
      chk("rst_rdy",   a_rdy, 3'b000);
      rst = 1'b0;

      step;
      chk("first_gnt", a_gnt, 3'b001);
      chk("first_idx", a_idx, 0);
      chk("first_act", a_act, 1);
      chk("first_rdy", a_rdy, 3'b001);

      // Rotation with all requesters valid.
      for (int k = 0; k < 6; k++) begin
         step;
         chk($sformatf("rot_gnt_%0d", k), a_gnt, rot_gnt[k]);
         chk($sformatf("rot_idx_%0d", k), a_idx, rot_idx[k]);
         chk($sformatf("rot_rdy_%0d", k), a_rdy, rot_gnt[k]);
      end

      // Owner 1 under backpressure.
      step;
      chk("bp_idle", a_gnt, 3'b000);
      a_ready = 1'b0;
      step;
      chk("bp_gnt", a_gnt, 3'b010);
      chk("bp_idx", a_idx, 1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_rdy_%0d", i), a_rdy, 3'b000);
         step;
         chk($sformatf("bp_hold_%0d", i), a_gnt, 3'b010);
      end
      a_ready = 1'b1;
      #1;
      chk("bp_rdy_on", a_rdy, 3'b010);
      step;
      chk("bp_rel", a_gnt, 3'b000);
      step;
      chk("bp_next_gnt", a_gnt, 3'b100);
      chk("bp_next_idx", a_idx, 2);

      // Owner drops VALID: grant held, no release.
      a_valid = 3'b011;
      step;
      chk("drop_hold_0", a_gnt, 3'b100);
      step;
      chk("drop_hold_1", a_gnt, 3'b100);
      a_valid = 3'b111;
      step;
      chk("drop_rel", a_gnt, 3'b000);
      step;
      chk("ptr0_gnt", a_gnt, 3'b001);

      // Pointer reaches 2 with only 0 and 1 requesting: wraps to 0.
      a_valid = 3'b011;
      step;
      chk("wrap_idle_0", a_gnt, 3'b000);
      step;
      chk("wrap_gnt1", a_gnt, 3'b010);
      step;
      chk("wrap_idle_1", a_gnt, 3'b000);
      step;
      chk("wrap_gnt", a_gnt, 3'b001);
      chk("wrap_idx", a_idx, 0);
      a_valid = 3'b000;
      a_ready = 1'b0;

      // Fixed priority: lowest index always wins.
      b_valid = 3'b110;
      b_ready = 1'b1;
      step;
      chk("fp_gnt_0", b_gnt, 3'b010);
      chk("fp_idx_0", b_idx, 1);
      step;
      chk("fp_idle_0", b_gnt, 3'b000);
      step;
      chk("fp_gnt_1", b_gnt, 3'b010);
      step;
      chk("fp_idle_1", b_gnt, 3'b000);
      b_valid = 3'b111;
      step;
      chk("fp_low_gnt", b_gnt, 3'b001);
      chk("fp_low_idx", b_idx, 0);
      b_valid = 3'b000;
      b_ready = 1'b0;

      // Burst mode: owner 0 holds for 4 beats; non-owner LAST is ignored.
      c_valid = 3'b111;
      c_ready = 1'b1;
      c_last  = 3'b110;
      step;
      chk("burst_gnt", c_gnt, 3'b001);
      for (int i = 0; i < 3; i++) begin
         step;
         chk($sformatf("burst_hold_%0d", i), c_gnt, 3'b001);
      end
      c_last = 3'b001;
      #1;
      chk("burst_rdy", c_rdy, 3'b001);
      step;
      chk("burst_rel", c_gnt, 3'b000);
      c_last = 3'b000;
      step;
      chk("burst_next_gnt", c_gnt, 3'b010);
      chk("burst_next_idx", c_idx, 1);
      step;
      chk("burst_next_hold", c_gnt, 3'b010);
      c_last = 3'b010;
      step;
      chk("burst_rel2", c_gnt, 3'b000);
      c_last = 3'b000;
      step;
      chk("mid_gnt", c_gnt, 3'b100);
      step;
      chk("mid_hold", c_gnt, 3'b100);

      // Reset in the middle of a burst clears grant and pointer.
      rst = 1'b1;
      step;
      chk("mid_rst_gnt", c_gnt, 3'b000);
      chk("mid_rst_act", c_act, 0);
      chk("mid_rst_idx", c_idx, 0);
      rst     = 1'b0;
      c_valid = 3'b101;
      step;
      chk("post_rst_gnt", c_gnt, 3'b001);
      chk("post_rst_idx", c_idx, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_rr_arbiter_n.md
Name: axi_rr_arbiter_n

Overview:
- Parametrised N-requester arbiter for the AXI interconnect, successor to the fixed two-input arbiter.
- Grants one requester at a time and holds the grant until the slave-side handshake completes, or until the last beat in burst mode.
- Round-robin or fixed-priority selection is chosen at elaboration.
- Sits in front of each shared AXI channel mux (AR/AW/W); the mux is steered by grant_idx.

Parameters:
NUM_REQ, 3, number of requesters (2..16); index NUM_REQ-1 is conventionally the default master
IDX_W, $clog2(NUM_REQ), width of grant_idx (derived, not overridden)
ROUND_ROBIN, 1, 1 = rotating priority after each release; 0 = fixed priority, lowest index wins
HOLD_TO_LAST, 0, 1 = grant released only on the handshake where req_last of the owner is 1 (W bursts); 0 = released on any handshake

Ports:
ACLK  input  1  clock
ARESET  input  1  reset, synchronous, active-high
req_valid  input  NUM_REQ  VALID from each requester
req_last  input  NUM_REQ  LAST from each requester (ignored when HOLD_TO_LAST=0)
out_ready  input  1  READY from the downstream slave/mux output
grant_onehot  output  NUM_REQ  registered one-hot grant, all-zero when idle
grant_idx  output  IDX_W  binary index of the owner; 0 when idle
grant_active  output  1  1 while a grant is held
req_ready  output  NUM_REQ  READY routed back: out_ready & grant_onehot[i], combinational

Behaviour:
- Interface: one clock (ACLK); reset is synchronous and active-high (ARESET). All state updates on posedge ACLK.
- Reset (ARESET=1 at a clock edge): grant_onehot=0, grant_idx=0, grant_active=0, priority pointer=0, state=IDLE. req_ready=0 as a consequence. Reset overrides everything, including a grant held mid-burst.
- States: IDLE and BUSY.
- IDLE:
  - If any req_valid is 1, pick a winner and go to BUSY at the next edge. Grant outputs are registered, so latency is 1 cycle from req_valid to grant.
  - If no req_valid is 1, stay in IDLE.
- Selection, ROUND_ROBIN=1: search from pointer p upward, modulo NUM_REQ; the first asserted req_valid wins.
- Selection, ROUND_ROBIN=0: the lowest asserted index wins; the pointer is unused and stays 0.
- BUSY, owner k:
  - A handshake is a cycle where req_valid[k] & out_ready.
  - Release condition: the handshake, and additionally req_last[k]=1 when HOLD_TO_LAST=1.
  - On release: go to IDLE at the next edge and set pointer = (k+1) mod NUM_REQ (wrap: NUM_REQ-1 -> 0).
  - Otherwise stay in BUSY; the grant is stable and no other requester can preempt.
- After every release there is exactly one IDLE cycle. Max throughput is one grant per 2 cycles for single-beat transfers; this is accepted.
- Requests from non-owners while BUSY are ignored. Their req_ready stays 0, and they must keep VALID asserted per AXI rules.
- If the owner drops req_valid while BUSY (a protocol violation), the grant is held and no release occurs. No timeout.
- Simultaneous events:
  - Release and new requests in the same cycle: the new requests are evaluated in the following IDLE cycle using the updated pointer.
  - ARESET and release in the same cycle: reset wins.
- Fairness, ROUND_ROBIN=1: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0. Worst-case wait is NUM_REQ-1 transactions.
- grant_onehot always has at most one bit set. grant_idx always equals the encoding of grant_onehot.

Decomposition:
- Shared package (axi_arb_pkg): arb_state_e enum {IDLE, BUSY}, and a function rr_pick(valid, ptr) returning a one-hot winner. The function is shared with future read/write-channel arbiters.
- One natural sub-module: rr_select, purely combinational. It rotates req_valid by the pointer, applies a priority encoder, and rotates back. The FSM, pointer and grant registers stay in axi_rr_arbiter_n.

Test Plan:
- Reset: hold ARESET=1 for 2 cycles with req_valid=3'b111 -> grant_onehot=0, grant_active=0 throughout; after release, first grant=3'b001 one cycle later.
- RR rotation: NUM_REQ=3, req_valid=3'b111 held, out_ready=1 -> grant_idx sequence 0,idle,1,idle,2,idle,0; each req_ready pulse is 1 cycle.
- Hold under backpressure: owner 1 granted, out_ready=0 for 5 cycles, req_valid=3'b111 -> grant_onehot stays 3'b010; req_ready stays 0; releases only on the cycle out_ready=1.
- Burst mode: HOLD_TO_LAST=1, owner 0 sends 4 beats with req_last only on beat 4 and out_ready=1 -> grant held 4 handshakes; the next grant goes to index 1 (pointer=1).
- Fixed priority and wrap: ROUND_ROBIN=0, req_valid=3'b110 -> grant 1 repeatedly; ROUND_ROBIN=1 with pointer=2 and req_valid=3'b011 -> grant 0 (wrap-around).
- Reset mid-burst: ARESET=1 while BUSY with owner 2 -> next cycle grant_onehot=0, pointer=0; on the following request 3'b101 the grant is 0.
